stlb_lookup_ctrl: RTL

- Sequences a single shared SV39 TLB lookup port between two requesters: index 0 = ITLB miss path, index 1 = DTLB miss path.
- On a TLB hit, returns the PTE to the winning requester.
- On a miss, launches a page-table walk, waits for the walker to write the TLB, then replays the lookup.
- Sits between the L1 TLB miss paths, the shared TLB instance and the PTW.

---
 rtl/stlb_lookup_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stlb_lookup_ctrl.sv
// Shared SV39 TLB lookup sequencer: arbitrates ITLB/DTLB miss paths onto one
// shared-TLB port, launches a page-table walk on a miss and replays after it.
module stlb_lookup_ctrl #(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned VLEN       = 39,
  parameter int unsigned MAX_REPLAY = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [1:0]                 req_i,
  input  logic [1:0][VLEN-1:0]       vaddr_i,
  input  logic [1:0][ASID_WIDTH-1:0] asid_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 resp_valid_o,
  output logic                       resp_err_o,
  output logic [63:0]                resp_pte_o,
  output logic                       resp_is_2M_o,
  output logic                       resp_is_1G_o,
  output logic                       lu_access_o,
  output logic [VLEN-1:0]            lu_vaddr_o,
  output logic [ASID_WIDTH-1:0]      lu_asid_o,
  input  logic                       lu_hit_i,
  input  logic [63:0]                lu_content_i,
  input  logic                       lu_is_2M_i,
  input  logic                       lu_is_1G_i,
  output logic                       ptw_req_o,
  output logic [VLEN-1:0]            ptw_vaddr_o,
  output logic [ASID_WIDTH-1:0]      ptw_asid_o,
  input  logic                       ptw_gnt_i,
  input  logic                       ptw_done_i,
  input  logic                       ptw_err_i,
  output logic                       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WALK_REQ,
    WALK_WAIT,
    FLUSH_DRAIN
  } state_e;

  localparam logic [2:0] MAX_REPLAY_CNT = 3'(MAX_REPLAY);

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  src_q, src_d;
  logic [2:0]            replay_cnt_q, replay_cnt_d;
  logic [VLEN-1:0]       vaddr_q, vaddr_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;

  logic winner;
  logic resp_fire;
  logic resp_err;
  logic resp_from_lu;
  logic lu_access;
  logic ptw_req;

  assign winner = (req_i == 2'b11) ? rr_q : req_i[1];

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    src_d        = src_q;
    replay_cnt_d = replay_cnt_q;
    vaddr_d      = vaddr_q;
    asid_d       = asid_q;
    gnt_o        = 2'b00;
    resp_fire    = 1'b0;
    resp_err     = 1'b0;
    resp_from_lu = 1'b0;
    lu_access    = 1'b0;
    ptw_req      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!flush_i && (req_i != 2'b00)) begin
          gnt_o[winner] = 1'b1;
          src_d         = winner;
          vaddr_d       = vaddr_i[winner];
          asid_d        = asid_i[winner];
          replay_cnt_d  = 3'd0;
          state_d       = LOOKUP;
        end
      end

      LOOKUP: begin
        lu_access = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (lu_hit_i) begin
          resp_fire    = 1'b1;
          resp_from_lu = 1'b1;
          rr_d         = ~src_q;
          state_d      = IDLE;
        end else if (replay_cnt_q == MAX_REPLAY_CNT) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          rr_d      = ~src_q;
          state_d   = IDLE;
        end else begin
          state_d = WALK_REQ;
        end
      end

      // The request stays up for the whole cycle even under flush, so a walker
      // granting in that cycle is tracked through FLUSH_DRAIN.
      WALK_REQ: begin
        ptw_req = 1'b1;
        if (flush_i) begin
          state_d = ptw_gnt_i ? FLUSH_DRAIN : IDLE;
        end else if (ptw_gnt_i) begin
          state_d = WALK_WAIT;
        end
      end

      WALK_WAIT: begin
        if (flush_i) begin
          state_d = (ptw_done_i || ptw_err_i) ? IDLE : FLUSH_DRAIN;
        end else if (ptw_err_i) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          rr_d      = ~src_q;
          state_d   = IDLE;
        end else if (ptw_done_i) begin
          replay_cnt_d = (replay_cnt_q == 3'd7) ? replay_cnt_q : replay_cnt_q + 3'd1;
          state_d      = LOOKUP;
        end
      end

      FLUSH_DRAIN: begin
        if (ptw_done_i || ptw_err_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      src_q        <= 1'b0;
      replay_cnt_q <= 3'd0;
      vaddr_q      <= '0;
      asid_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      src_q        <= src_d;
      replay_cnt_q <= replay_cnt_d;
      vaddr_q      <= vaddr_d;
      asid_q       <= asid_d;
    end
  end

  // Data outputs are forced to zero whenever their strobe is low.
  assign resp_valid_o = resp_fire ? {src_q, ~src_q} : 2'b00;
  assign resp_err_o   = resp_fire & resp_err;
  assign resp_pte_o   = (resp_fire && resp_from_lu) ? lu_content_i : 64'd0;
  assign resp_is_2M_o = resp_fire & resp_from_lu & lu_is_2M_i;
  assign resp_is_1G_o = resp_fire & resp_from_lu & lu_is_1G_i;

  assign lu_access_o  = lu_access;
  assign lu_vaddr_o   = lu_access ? vaddr_q : '0;
  assign lu_asid_o    = lu_access ? asid_q  : '0;

  assign ptw_req_o    = ptw_req;
  assign ptw_vaddr_o  = ptw_req ? vaddr_q : '0;
  assign ptw_asid_o   = ptw_req ? asid_q  : '0;

  assign busy_o       = (state_q != IDLE);

endmodule
